mult_seq_param: RTL and testbench

Parametrised iterative multiplier that supersedes the fixed 5-bit multiplier behind `mult_if`. It adds three things:
- configurable operand width;
- configurable bits retired per cycle;
- a per-transaction signed/unsigned mode.

It keeps the req/rdy/done handshake, so the existing testbench-top structure (free-running `clk`, interface-connected DUT and bench) carries over with a widened interface.

---
 rtl/mult_seq_param.sv | 126 ++++++++++++
 tb/tb_mult_seq_param.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_seq_param.sv
`default_nettype none
// ============================================================================
// mult_seq_param : iterative WIDTH x WIDTH multiplier, BPC multiplier bits/cycle,
//                  per-transaction signed/unsigned mode, req/rdy/done handshake
// Revision       : 1.0
// ============================================================================
module mult_seq_param #(
  parameter int WIDTH = 5,
  parameter int BPC   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req,
  input  logic               sgn,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               rdy,
  output logic               done,
  output logic [2*WIDTH-1:0] ab
);

  localparam int C_N  = WIDTH / BPC;
  localparam int C_CW = $clog2(C_N + 1);
  localparam int C_W2 = 2 * WIDTH;

  generate
    if (WIDTH < 2 || (WIDTH % BPC) != 0) begin : g_bad_params
      $error("mult_seq_param: WIDTH must be >= 2 and an exact multiple of BPC");
    end
  endgenerate

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_start;
  logic              w_finish;

  logic [C_W2-1:0]   r_mcand;
  logic [WIDTH-1:0]  r_mplr;
  logic [C_CW-1:0]   r_cnt;
  logic [C_W2-1:0]   r_acc;
  logic              r_neg;
  logic [C_W2-1:0]   r_ab;
  logic              r_done;

  logic [WIDTH-1:0]  w_mag_a;
  logic [WIDTH-1:0]  w_mag_b;
  logic [C_W2-1:0]   w_pp;
  logic [C_W2-1:0]   w_acc_nxt;

  // Magnitude of the most negative operand is 2^(WIDTH-1), still fits unsigned.
  assign w_mag_a   = (sgn && a[WIDTH-1]) ? -a : a;
  assign w_mag_b   = (sgn && b[WIDTH-1]) ? -b : b;

  // Multiplicand is pre-shifted each cycle, so it already sits at the bit offset.
  assign w_pp      = r_mcand * C_W2'(r_mplr[BPC-1:0]);
  assign w_acc_nxt = r_acc + w_pp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req) begin
          w_state_nxt = S_BUSY;
          w_start     = 1'b1;
        end
      end
      S_BUSY: begin
        if (r_cnt == C_CW'(1)) begin
          w_state_nxt = S_IDLE;
          w_finish    = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand <= '0;
      r_mplr  <= '0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_neg   <= 1'b0;
      r_ab    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_start) begin
        r_mcand <= {{WIDTH{1'b0}}, w_mag_a};
        r_mplr  <= w_mag_b;
        r_cnt   <= C_CW'(C_N);
        r_acc   <= '0;
        r_neg   <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
      end else if (r_state == S_BUSY) begin
        r_acc   <= w_acc_nxt;
        r_mcand <= r_mcand << BPC;
        r_mplr  <= r_mplr >> BPC;
        r_cnt   <= r_cnt - C_CW'(1);
        if (w_finish) begin
          r_ab <= r_neg ? -w_acc_nxt : w_acc_nxt;
        end
      end
    end
  end

  assign rdy  = (r_state == S_IDLE);
  assign done = r_done;
  assign ab   = r_ab;

endmodule
`default_nettype wire

// File: tb/tb_mult_seq_param.sv
`default_nettype none
// Bench for mult_seq_param: default (5,1) and (8,2) instances, table vectors,
// random operands against an integer-arithmetic model, multi-cycle corner cases.
module tb_mult_seq_param;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        req5 = 1'b0, sgn5 = 1'b0;
  logic [4:0]  a5 = '0, b5 = '0;
  logic        rdy5, done5;
  logic [9:0]  ab5;

  logic        req8 = 1'b0, sgn8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        rdy8, done8;
  logic [15:0] ab8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mult_seq_param #(.WIDTH(5), .BPC(1)) dut5 (
    .clk(clk), .rst_n(rst_n), .req(req5), .sgn(sgn5), .a(a5), .b(b5),
    .rdy(rdy5), .done(done5), .ab(ab5)
  );

  mult_seq_param #(.WIDTH(8), .BPC(2)) dut8 (
    .clk(clk), .rst_n(rst_n), .req(req8), .sgn(sgn8), .a(a8), .b(b8),
    .rdy(rdy8), .done(done8), .ab(ab8)
  );

  typedef struct {
    logic        s;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [15:0] e;
  } vec_t;

  vec_t t5[7];
  vec_t t8[4];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: interpret operands as integers, multiply, wrap to 2*w bits.
  function automatic longint model(input bit s, input longint x, input longint y, input int w);
    longint lim, vx, vy;
    lim = longint'(1) << w;
    vx  = x;
    vy  = y;
    if (s && vx >= lim / 2) vx -= lim;
    if (s && vy >= lim / 2) vy -= lim;
    return (vx * vy) & ((lim * lim) - 1);
  endfunction

  task automatic op5(input string nm, input logic s, input logic [4:0] x,
                     input logic [4:0] y, input logic [9:0] e);
    int k = 0;
    @(negedge clk);
    sgn5 = s; a5 = x; b5 = y; req5 = 1'b1;
    @(negedge clk);
    req5 = 1'b0;
    a5 = 5'($urandom); b5 = 5'($urandom); sgn5 = 1'($urandom);
    chk({nm, " rdy_low"}, 64'(rdy5), 64'(0));
    while (!done5 && k < 20) begin
      @(negedge clk);
      if (!done5) chk({nm, " rdy_busy"}, 64'(rdy5), 64'(0));
      k++;
    end
    chk({nm, " latency"}, 64'(k), 64'(5));
    chk({nm, " ab"}, 64'(ab5), 64'(e));
    chk({nm, " rdy_back"}, 64'(rdy5), 64'(1));
    @(negedge clk);
    chk({nm, " done_fall"}, 64'(done5), 64'(0));
    chk({nm, " ab_hold"}, 64'(ab5), 64'(e));
  endtask

  task automatic op8(input string nm, input logic s, input logic [7:0] x,
                     input logic [7:0] y, input logic [15:0] e);
    int k = 0;
    @(negedge clk);
    sgn8 = s; a8 = x; b8 = y; req8 = 1'b1;
    @(negedge clk);
    req8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); sgn8 = 1'($urandom);
    chk({nm, " rdy_low"}, 64'(rdy8), 64'(0));
    while (!done8 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk({nm, " latency"}, 64'(k), 64'(4));
    chk({nm, " ab"}, 64'(ab8), 64'(e));
    @(negedge clk);
    chk({nm, " done_fall"}, 64'(done8), 64'(0));
    chk({nm, " ab_hold"}, 64'(ab8), 64'(e));
  endtask

  initial begin
    t5[0] = '{1'b0, 8'd31, 8'd31, 16'h3C1};
    t5[1] = '{1'b1, 8'h10, 8'h10, 16'h100};
    t5[2] = '{1'b1, 8'h1D, 8'h07, 16'h3EB};
    t5[3] = '{1'b1, 8'h10, 8'h00, 16'h000};
    t5[4] = '{1'b1, 8'h0F, 8'h1F, 16'h3F1};
    t5[5] = '{1'b1, 8'h1F, 8'h01, 16'h3FF};
    t5[6] = '{1'b0, 8'h10, 8'h1F, 16'h1F0};
    t8[0] = '{1'b0, 8'd255, 8'd255, 16'hFE01};
    t8[1] = '{1'b1, 8'h80, 8'h7F, 16'hC080};
    t8[2] = '{1'b1, 8'h80, 8'h80, 16'h4000};
    t8[3] = '{1'b0, 8'd200, 8'd3, 16'h0258};

    // Reset then idle
    repeat (2) @(negedge clk);
    chk("rst rdy", 64'(rdy5), 64'(1));
    chk("rst done", 64'(done5), 64'(0));
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle rdy", 64'(rdy5), 64'(1));
      chk("idle done", 64'(done5), 64'(0));
      chk("idle ab", 64'(ab5), 64'(0));
      chk("idle8 ab", 64'(ab8), 64'(0));
    end

    for (int i = 0; i < 7; i++)
      op5($sformatf("vec5_%0d", i), t5[i].s, t5[i].x[4:0], t5[i].y[4:0], t5[i].e[9:0]);
    for (int i = 0; i < 4; i++)
      op8($sformatf("vec8_%0d", i), t8[i].s, t8[i].x, t8[i].y, t8[i].e);

    for (int i = 0; i < 30; i++) begin
      logic s; logic [4:0] x, y;
      s = 1'($urandom); x = 5'($urandom); y = 5'($urandom);
      op5($sformatf("rnd5_%0d", i), s, x, y, 10'(model(s, longint'(x), longint'(y), 5)));
    end
    for (int i = 0; i < 30; i++) begin
      logic s; logic [7:0] x, y;
      s = 1'($urandom); x = 8'($urandom); y = 8'($urandom);
      op8($sformatf("rnd8_%0d", i), s, x, y, 16'(model(s, longint'(x), longint'(y), 8)));
    end

    // Back-to-back with req held high; operand changes while busy must not matter
    begin
      int d1 = -1, d2 = -1, nd = 0;
      logic [9:0] r1 = '0, r2 = '0;
      @(negedge clk);
      sgn5 = 1'b0; a5 = 5'd3; b5 = 5'd4; req5 = 1'b1;
      @(negedge clk);
      a5 = 5'd5; b5 = 5'd6;
      for (int k = 1; k <= 16; k++) begin
        @(negedge clk);
        if (k == 6) begin req5 = 1'b0; a5 = 5'd7; b5 = 5'd7; end
        if (done5) begin
          nd++;
          if (d1 < 0) begin d1 = k; r1 = ab5; end
          else if (d2 < 0) begin d2 = k; r2 = ab5; end
        end
      end
      chk("b2b first_cycle", 64'(d1), 64'(5));
      chk("b2b first_ab", 64'(r1), 64'(12));
      chk("b2b second_cycle", 64'(d2), 64'(11));
      chk("b2b second_ab", 64'(r2), 64'(30));
      chk("b2b done_count", 64'(nd), 64'(2));
    end

    // Reset mid-operation, asserted between edges
    begin
      int nd = 0;
      @(negedge clk);
      sgn5 = 1'b0; a5 = 5'd9; b5 = 5'd9; req5 = 1'b1;
      @(negedge clk);
      req5 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst rdy", 64'(rdy5), 64'(1));
      chk("midrst ab", 64'(ab5), 64'(0));
      chk("midrst done", 64'(done5), 64'(0));
      chk("midrst ab8", 64'(ab8), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        if (done5) nd++;
      end
      chk("midrst no_done", 64'(nd), 64'(0));
      chk("midrst ab_after", 64'(ab5), 64'(0));
    end
    op5("restart", 1'b0, 5'd2, 5'd3, 10'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
